// File: rtl/expr_eval_ctrl.sv
// Streaming evaluator for single-digit "+"/"*" expressions terminated by '='.
// Multiplication binds tighter than addition; results wrap modulo 2^W.
module expr_eval_ctrl #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] result,
    output logic         err
);

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_NINE = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_EQ   = 8'h3D;

    typedef enum logic [1:0] {
        EXP_DIG,
        EXP_OP,
        ERR,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] s_q;
    logic [W-1:0] s_nxt;
    logic [W-1:0] p_q;
    logic [W-1:0] p_nxt;
    logic [W-1:0] result_nxt;
    logic         err_nxt;
    logic         out_valid_nxt;

    logic         xfer;
    logic         is_digit;
    logic         is_plus;
    logic         is_mul;
    logic         is_eq;
    logic [W-1:0] digit_val;

    // Ready is withheld during reset and for the single result cycle.
    assign in_ready  = !clr && (state != DONE);
    assign xfer      = in_valid && in_ready;
    assign is_digit  = (in >= CH_ZERO) && (in <= CH_NINE);
    assign is_plus   = (in == CH_PLUS);
    assign is_mul    = (in == CH_MUL);
    assign is_eq     = (in == CH_EQ);
    assign digit_val = W'(in - CH_ZERO);

    // Next-state and datapath updates; S holds finished terms, P the open product.
    always_comb begin
        state_nxt     = state;
        s_nxt         = s_q;
        p_nxt         = p_q;
        result_nxt    = result;
        err_nxt       = err;
        out_valid_nxt = 1'b0;

        case (state)
            EXP_DIG: begin
                if (xfer) begin
                    if (is_digit) begin
                        p_nxt     = p_q * digit_val;
                        state_nxt = EXP_OP;
                    end else if (is_eq) begin
                        result_nxt    = '0;
                        err_nxt       = 1'b1;
                        out_valid_nxt = 1'b1;
                        state_nxt     = DONE;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
            EXP_OP: begin
                if (xfer) begin
                    if (is_mul) begin
                        state_nxt = EXP_DIG;
                    end else if (is_plus) begin
                        s_nxt     = s_q + p_q;
                        p_nxt     = W'(1);
                        state_nxt = EXP_DIG;
                    end else if (is_eq) begin
                        result_nxt    = s_q + p_q;
                        err_nxt       = 1'b0;
                        out_valid_nxt = 1'b1;
                        state_nxt     = DONE;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
            ERR: begin
                if (xfer && is_eq) begin
                    result_nxt    = '0;
                    err_nxt       = 1'b1;
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                s_nxt     = '0;
                p_nxt     = W'(1);
                state_nxt = EXP_DIG;
            end
            default: begin
                state_nxt = EXP_DIG;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= EXP_DIG;
            s_q       <= '0;
            p_q       <= W'(1);
            result    <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            s_q       <= s_nxt;
            p_q       <= p_nxt;
            result    <= result_nxt;
            err       <= err_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Bench for expr_eval_ctrl: W=32 and W=8 instances share one stimulus stream
// and are compared each cycle against a string-evaluating reference model.
module tb_expr_eval_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  in;
    logic        in_valid;

    logic        rdy32, ov32, err32;
    logic [31:0] res32;
    logic        rdy8, ov8, err8;
    logic [7:0]  res8;

    int nchk = 0;
    int nerr = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    expr_eval_ctrl #(.W(32)) u32 (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .in_ready(rdy32), .out_valid(ov32), .result(res32), .err(err32)
    );

    expr_eval_ctrl #(.W(8)) u8 (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .in_ready(rdy8), .out_valid(ov8), .result(res8), .err(err8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect the bytes of an expression, evaluate on '='.
    logic [7:0]  mq[$];
    logic        m_ov = 1'b0;
    logic [31:0] m_res32 = '0;
    logic [7:0]  m_res8 = '0;
    logic        m_err = 1'b0;
    logic [31:0] s32, p32;
    logic [7:0]  s8, p8, c;
    logic        bad;

    always @(posedge clk) begin
        if (clr) begin
            mq.delete();
            m_ov = 1'b0; m_res32 = '0; m_res8 = '0; m_err = 1'b0;
        end else if (m_ov) begin
            m_ov = 1'b0;
            mq.delete();
        end else if (in_valid) begin
            if (in == 8'h3D) begin
                bad = (mq.size() % 2 == 0);
                s32 = 0; p32 = 1; s8 = 0; p8 = 1;
                for (int i = 0; i < mq.size(); i++) begin
                    c = mq[i];
                    if (i % 2 == 0) begin
                        if (c >= "0" && c <= "9") begin
                            p32 = p32 * 32'(c - 8'h30);
                            p8  = p8 * (c - 8'h30);
                        end else bad = 1'b1;
                    end else if (c == "+") begin
                        s32 = s32 + p32; p32 = 1;
                        s8  = s8 + p8;   p8  = 1;
                    end else if (c != "*") begin
                        bad = 1'b1;
                    end
                end
                m_err   = bad;
                m_res32 = bad ? 32'd0 : s32 + p32;
                m_res8  = bad ? 8'd0 : s8 + p8;
                m_ov    = 1'b1;
                mq.delete();
            end else begin
                mq.push_back(in);
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready32", 32'(rdy32), 32'(!clr && !m_ov));
            chk("in_ready8",  32'(rdy8),  32'(!clr && !m_ov));
            chk("out_valid32", 32'(ov32), 32'(m_ov));
            chk("out_valid8",  32'(ov8),  32'(m_ov));
            chk("result32", res32, m_res32);
            chk("result8",  32'(res8), 32'(m_res8));
            chk("err32", 32'(err32), 32'(m_err));
            chk("err8",  32'(err8),  32'(m_err));
        end
    end

    // Present a byte and hold it until accepted; returns at edge+1.
    task automatic send_byte(input logic [7:0] b);
        logic done;
        done = 1'b0;
        in = b;
        in_valid = 1'b1;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (rdy32) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout: byte %0h never accepted", b);
        end
    endtask

    // Stream an expression; after '=' is accepted we are in the result cycle.
    task automatic run_expr(input string s, input int gaps,
                            input logic [31:0] e32, input logic [7:0] e8, input logic ee);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (gaps > 0 && i < s.len() - 1) begin
                in_valid = 1'b0;
                in = 8'h2B;
                repeat (gaps) @(posedge clk);
                #1;
            end
        end
        chk({"lit_ov ", s}, 32'(ov32), 32'd1);
        chk({"lit_res32 ", s}, res32, e32);
        chk({"lit_res8 ", s}, 32'(res8), 32'(e8));
        chk({"lit_err ", s}, 32'(err32), 32'(ee));
    endtask

    initial begin
        clr = 1'b1;
        in = 8'h35;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy32), 32'd0);
        chk("rst_ov", 32'(ov32), 32'd0);
        chk("rst_res", res32, 32'd0);
        chk("rst_err", 32'(err32), 32'd0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Streams are back-to-back, so each next first byte waits out DONE.
        run_expr("1+2*3=",   0, 32'd7,  8'd7,  1'b0);
        run_expr("2*3*4+5=", 0, 32'd29, 8'd29, 1'b0);
        run_expr("0*9+8=",   0, 32'd8,  8'd8,  1'b0);
        run_expr("1++2=",    0, 32'd0,  8'd0,  1'b1);
        run_expr("=",        0, 32'd0,  8'd0,  1'b1);
        run_expr("9=",       0, 32'd9,  8'd9,  1'b0);
        run_expr("7a=",      0, 32'd0,  8'd0,  1'b1);
        run_expr("5+=",      0, 32'd0,  8'd0,  1'b1);
        run_expr("8*7=",     2, 32'd56, 8'd56, 1'b0);
        run_expr("9*9*9=",   0, 32'd729, 8'd217, 1'b0);
        run_expr("9*9*9*9*9*9*9*9*9*9+1=", 0, 32'd3486784402, 8'd146, 1'b0);

        // Reset mid-expression discards the partial "3*".
        send_byte("3");
        send_byte("*");
        clr = 1'b1;
        in = 8'h35;
        @(posedge clk);
        #1;
        clr = 1'b0;
        run_expr("4=", 0, 32'd4, 8'd4, 1'b0);

        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_res", res32, 32'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_ov", 32'(ov32), 32'd0);
        chk("hold_res_late", res32, 32'd4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
